timer_counter: RTL and testbench

- Upstream stage of the timer interrupt logic.
- Produces the free-running 64-bit `cnt_val` that the interrupt stage compares against `compare_val`.
- Provides a programmable prescaler, global enable, and 32-bit software load of the low and high counter words from the register block.
- Provides a debug halt handshake that freezes counting while a debugger holds the core.

---
 rtl/timer_pkg.sv | 12 +
 rtl/timer_prescaler.sv | 59 +++++
 rtl/timer_counter.sv | 82 ++++++++
 tb/tb_timer_counter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared timer definitions: counter/word widths, default prescaler width
// and the halt FSM state encoding.
package timer_pkg;
  localparam int CNT_WIDTH     = 64;
  localparam int WORD_WIDTH    = 32;
  localparam int DEF_DIV_WIDTH = 8;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } halt_state_e;
endpackage

// File: rtl/timer_prescaler.sv
// Programmable prescaler for the timer counter.
// Ports:
//   sys_clk, sys_rst_n : clock, async active-low reset
//   timer_en           : 0 clears the phase and blocks inc
//   div_en, div_val    : prescaler mode / terminal value (ratio div_val+1)
//   freeze             : hold everything (halt in progress)
//   inc                : combinational, counter should increment this cycle
module timer_prescaler #(
  parameter int DIV_WIDTH = timer_pkg::DEF_DIV_WIDTH
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 timer_en,
  input  logic                 div_en,
  input  logic [DIV_WIDTH-1:0] div_val,
  input  logic                 freeze,
  output logic                 inc
);
  logic [DIV_WIDTH-1:0] div_cnt, div_cnt_nxt;
  logic [DIV_WIDTH-1:0] div_val_q;
  logic                 div_en_q;
  logic                 cfg_chg;

  // Copies only advance while running, so a config change made during a
  // halt is still seen (and restarts the phase) on the first running cycle.
  assign cfg_chg = (div_en != div_en_q) || (div_val != div_val_q);

  always_comb begin
    inc         = 1'b0;
    div_cnt_nxt = div_cnt;
    if (!freeze) begin
      if (!timer_en || cfg_chg) begin
        div_cnt_nxt = '0;
      end else if (!div_en) begin
        div_cnt_nxt = '0;
        inc         = 1'b1;
      end else if (div_cnt == div_val) begin
        div_cnt_nxt = '0;
        inc         = 1'b1;
      end else begin
        div_cnt_nxt = div_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div_cnt   <= '0;
      div_val_q <= '0;
      div_en_q  <= 1'b0;
    end else begin
      div_cnt <= div_cnt_nxt;
      if (!freeze) begin
        div_val_q <= div_val;
        div_en_q  <= div_en;
      end
    end
  end
endmodule

// File: rtl/timer_counter.sv
// Free-running 64-bit timer counter with prescaler, software word loads
// and a debug halt handshake.
// Ports:
//   sys_clk, sys_rst_n   : clock, async active-low reset
//   timer_en, div_en,
//   div_val              : enable and prescaler control
//   cnt_wdata, cnt_lo_wr,
//   cnt_hi_wr            : software load of low/high counter word
//   debug_mode, halt_req : debugger freeze request (needs both)
//   cnt_val              : registered counter value
//   cnt_tick             : registered pulse, cycle after each increment
//   halt_ack             : registered, timer is frozen
module timer_counter
  import timer_pkg::*;
#(
  parameter int                   DIV_WIDTH   = DEF_DIV_WIDTH,
  parameter logic [CNT_WIDTH-1:0] CNT_RST_VAL = '0
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  timer_en,
  input  logic                  div_en,
  input  logic [DIV_WIDTH-1:0]  div_val,
  input  logic [WORD_WIDTH-1:0] cnt_wdata,
  input  logic                  cnt_lo_wr,
  input  logic                  cnt_hi_wr,
  input  logic                  debug_mode,
  input  logic                  halt_req,
  output logic [CNT_WIDTH-1:0]  cnt_val,
  output logic                  cnt_tick,
  output logic                  halt_ack
);
  halt_state_e state, state_nxt;
  logic        hold, freeze, inc, write;

  assign hold   = debug_mode & halt_req;
  // Freeze is combinational on hold so the request cycle itself is frozen.
  assign freeze = hold | (state == HALTED);
  assign write  = cnt_lo_wr | cnt_hi_wr;

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (hold)  state_nxt = HALTED;
      HALTED:  if (!hold) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= RUN;
    else            state <= state_nxt;
  end

  assign halt_ack = (state == HALTED);

  timer_prescaler #(.DIV_WIDTH(DIV_WIDTH)) u_presc (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .timer_en  (timer_en),
    .div_en    (div_en),
    .div_val   (div_val),
    .freeze    (freeze),
    .inc       (inc)
  );

  // Writes win over increment; a suppressed increment is dropped.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_val  <= CNT_RST_VAL;
      cnt_tick <= 1'b0;
    end else begin
      if (write) begin
        if (cnt_lo_wr) cnt_val[WORD_WIDTH-1:0]         <= cnt_wdata;
        if (cnt_hi_wr) cnt_val[CNT_WIDTH-1:WORD_WIDTH] <= cnt_wdata;
      end else if (inc) begin
        cnt_val <= cnt_val + 64'd1;
      end
      cnt_tick <= inc & ~write;
    end
  end
endmodule

// File: tb/tb_timer_counter.sv
// Scoreboard bench for timer_counter: a driver applies directed and random
// stimulus at the falling edge and pushes the model's expected outputs; a
// monitor pops and compares them just after each rising edge.
module tb_timer_counter;
  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        timer_en = 1'b0, div_en = 1'b0;
  logic [7:0]  div_val = '0;
  logic [31:0] cnt_wdata = '0;
  logic        cnt_lo_wr = 1'b0, cnt_hi_wr = 1'b0;
  logic        debug_mode = 1'b0, halt_req = 1'b0;
  logic [63:0] cnt_val;
  logic        cnt_tick, halt_ack;

  timer_counter dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .timer_en(timer_en),
    .div_en(div_en), .div_val(div_val), .cnt_wdata(cnt_wdata),
    .cnt_lo_wr(cnt_lo_wr), .cnt_hi_wr(cnt_hi_wr), .debug_mode(debug_mode),
    .halt_req(halt_req), .cnt_val(cnt_val), .cnt_tick(cnt_tick),
    .halt_ack(halt_ack)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [63:0] cnt;
    logic        tick;
    logic        ack;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference state: counter value, prescaler phase, last seen config, halted.
  logic [63:0] m_cnt;
  int          m_ph;
  logic        m_en_q;
  logic [7:0]  m_val_q;
  logic        m_halted;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_cnt = 64'h0; m_ph = 0; m_en_q = 1'b0; m_val_q = 8'h0; m_halted = 1'b0;
  endtask

  // Advance the model by one clock using the currently driven inputs.
  task automatic cycle();
    logic frz, inc, wr, hold;
    exp_t e;
    hold = debug_mode & halt_req;
    frz  = hold | m_halted;
    inc  = 1'b0;
    if (!frz) begin
      logic chg;
      chg = (div_en != m_en_q) || (div_val != m_val_q);
      m_en_q = div_en; m_val_q = div_val;
      if (!timer_en || chg)          m_ph = 0;
      else if (!div_en)              begin m_ph = 0; inc = 1'b1; end
      else if (m_ph == int'(div_val)) begin m_ph = 0; inc = 1'b1; end
      else                           m_ph++;
    end
    wr = cnt_lo_wr | cnt_hi_wr;
    if (wr) begin
      if (cnt_lo_wr) m_cnt[31:0]  = cnt_wdata;
      if (cnt_hi_wr) m_cnt[63:32] = cnt_wdata;
    end else if (inc) m_cnt = m_cnt + 64'd1;
    m_halted = hold;
    e.cnt = m_cnt; e.tick = inc & ~wr; e.ack = m_halted;
    q.push_back(e);
    @(negedge sys_clk);
    cnt_lo_wr = 1'b0; cnt_hi_wr = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Monitor: every cycle is an output cycle; compare after the edge settles.
  always @(posedge sys_clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("cnt_val",  cnt_val,         e.cnt);
      chk("cnt_tick", 64'(cnt_tick),   64'(e.tick));
      chk("halt_ack", 64'(halt_ack),   64'(e.ack));
    end
  end

  task automatic async_reset(input string tag);
    #2 sys_rst_n = 1'b0;
    #1;
    chk({tag, "_rst_cnt"},  cnt_val,       64'h0);
    chk({tag, "_rst_tick"}, 64'(cnt_tick), 64'h0);
    chk({tag, "_rst_ack"},  64'(halt_ack), 64'h0);
    q.delete();
    model_reset();
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  logic [63:0] frozen;

  initial begin
    model_reset();
    #1;
    chk("reset_cnt",  cnt_val,       64'h0);
    chk("reset_ack",  64'(halt_ack), 64'h0);
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // Count every cycle.
    timer_en = 1'b1; div_en = 1'b0; div_val = 8'd0;
    run(10);
    chk("count10", cnt_val, 64'd10);

    // Divide by 4 from zero (the write cycle is also the config-change cycle).
    div_en = 1'b1; div_val = 8'd3;
    cnt_wdata = 32'h0; cnt_lo_wr = 1'b1; cnt_hi_wr = 1'b1;
    cycle();
    run(16);
    chk("div4_16cyc", cnt_val, 64'd4);
    run(2);
    div_val = 8'd5;  // mid-phase change restarts the phase
    run(14);

    // 64-bit wrap.
    div_en = 1'b0;
    cnt_wdata = 32'hFFFF_FFFF; cnt_hi_wr = 1'b1;
    cycle();
    cnt_wdata = 32'hFFFF_FFFE; cnt_lo_wr = 1'b1;
    cycle();
    chk("wrap_pre", cnt_val, 64'hFFFF_FFFF_FFFF_FFFE);
    run(2);
    chk("wrap_zero", cnt_val, 64'h0);
    run(1);
    chk("wrap_one", cnt_val, 64'h1);

    // Write collides with increment.
    cnt_wdata = 32'd5; cnt_lo_wr = 1'b1;
    cycle();
    cnt_wdata = 32'd100; cnt_lo_wr = 1'b1;
    cycle();
    chk("wr_beats_inc", cnt_val, 64'd100);
    chk("wr_no_tick", 64'(cnt_tick), 64'h0);
    run(1);
    chk("after_wr_inc", cnt_val, 64'd101);

    // Halt request ignored outside debug mode, then honoured.
    div_en = 1'b1; div_val = 8'd2;
    run(4);
    halt_req = 1'b1;
    run(5);
    chk("no_dbg_no_ack", 64'(halt_ack), 64'h0);
    frozen = cnt_val;
    debug_mode = 1'b1;
    run(20);
    chk("halt_frozen", cnt_val, frozen);
    chk("halt_ack_on", 64'(halt_ack), 64'h1);
    async_reset("mid_halt");
    halt_req = 1'b0; debug_mode = 1'b0;
    run(3);
    halt_req = 1'b1; debug_mode = 1'b1;
    run(7);
    halt_req = 1'b0;
    run(8);

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      timer_en   = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 29) == 0) div_en  = $urandom_range(0, 1);
      if ($urandom_range(0, 29) == 0) div_val = 8'($urandom_range(0, 4));
      if ($urandom_range(0, 15) == 0) debug_mode = ~debug_mode;
      if ($urandom_range(0, 9) == 0)  halt_req   = ~halt_req;
      cnt_wdata = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF - $urandom_range(0, 3) : $urandom;
      cnt_lo_wr = ($urandom_range(0, 24) == 0);
      cnt_hi_wr = ($urandom_range(0, 24) == 0);
      cycle();
      if (i == 700) begin
        q.delete();
        async_reset("mid_count");
      end
    end
    halt_req = 1'b0;
    run(2);
    @(negedge sys_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
